// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
// Pure declarations: no latency, no flow control.
package fifo_arb_pkg;

  typedef enum logic {IDLE, BURST} arb_state_t;

  // Requester index width; a single requester still needs one bit.
  function automatic int idx_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  // Beat counter must be able to hold MAX_BURST itself.
  function automatic int cnt_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side and FIFO-write-side signals of the arbiter, bundled.
// master = arbiter view; slave = producers/FIFO environment view.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
);
  localparam int IDX_W = idx_w(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          w_en;
  logic [DATA_WIDTH-1:0]         data_in;
  logic                          full;
  logic                          write_error;
  logic [IDX_W-1:0]              grant_id;
  logic                          busy;
  logic                          err_sticky;

  modport master (
    input  req_valid, req_data, req_last, full, write_error,
    output req_ready, w_en, data_in, grant_id, busy, err_sticky
  );

  modport slave (
    output req_valid, req_data, req_last, full, write_error,
    input  req_ready, w_en, data_in, grant_id, busy, err_sticky
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin pick: first set bit of req at or after rr_ptr, wrapping.
// Zero latency; idx is meaningless when found is low.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  int cand;

  // Scan farthest-first so the nearest candidate to rr_ptr is written last.
  always_comb begin
    found = |req;
    idx   = rr_ptr;
    cand  = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (req[cand]) idx = IDX_W'(cand);
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for the FIFO write port; data_in/w_en are zero-latency muxes.
// One IDLE cycle between bursts; full stalls the granted requester without losing the grant.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic               w_clk,
  input  logic               wrst_n,
  fifo_wr_arbiter_if.master  bus
);

  localparam int IDX_W = idx_w(NUM_REQ);
  localparam int CNT_W = cnt_w(MAX_BURST);

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [IDX_W-1:0] grant_id, grant_nxt;
  logic [CNT_W-1:0] beat_cnt, cnt_nxt;
  logic             err_sticky;

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic             g_valid, g_last, in_burst;
  logic [IDX_W-1:0] ptr_after;

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req    (bus.req_valid),
    .rr_ptr (rr_ptr),
    .found  (pick_found),
    .idx    (pick_idx)
  );

  assign g_valid   = bus.req_valid[grant_id];
  assign g_last    = bus.req_last[grant_id];
  assign ptr_after = (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
  assign in_burst  = wrst_n && (state == BURST);

  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    grant_nxt  = grant_id;
    cnt_nxt    = beat_cnt;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt = BURST;
          grant_nxt = pick_idx;
          cnt_nxt   = '0;
        end
      end
      BURST: begin
        if (!g_valid) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = ptr_after;
        end else if (!bus.full) begin
          cnt_nxt = beat_cnt + 1'b1;
          if (g_last || beat_cnt == CNT_W'(MAX_BURST - 1)) begin
            state_nxt  = IDLE;
            rr_ptr_nxt = ptr_after;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are gated by wrst_n so they drop the instant reset asserts.
  always_comb begin
    bus.req_ready = '0;
    bus.w_en      = 1'b0;
    bus.data_in   = '0;
    if (in_burst) begin
      bus.req_ready[grant_id] = !bus.full;
      bus.w_en                = g_valid && !bus.full;
      bus.data_in             = bus.req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign bus.busy       = in_burst;
  assign bus.grant_id   = grant_id;
  assign bus.err_sticky = err_sticky;

  always_ff @(posedge w_clk or negedge wrst_n) begin
    if (!wrst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      grant_id   <= '0;
      beat_cnt   <= '0;
      err_sticky <= 1'b0;
    end else begin
      state      <= state_nxt;
      rr_ptr     <= rr_ptr_nxt;
      grant_id   <= grant_nxt;
      beat_cnt   <= cnt_nxt;
      err_sticky <= err_sticky | bus.write_error;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench: producer queues feed the arbiter, a negedge monitor checks every FIFO write
// against a scoreboard of hand-ordered beats; directed checks cover reset, stalls and abandons.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int MB = 4;
  localparam int DEPTH = 64;

  typedef struct packed {
    logic [1:0]    id;
    logic [DW-1:0] dat;
  } exp_t;

  logic w_clk  = 1'b0;
  logic wrst_n = 1'b0;
  always #5 w_clk = ~w_clk;

  fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
    .w_clk  (w_clk),
    .wrst_n (wrst_n),
    .bus    (bus)
  );

  logic [DW-1:0] pd [NR][DEPTH];
  logic          pl [NR][DEPTH];
  int            head [NR];
  int            tail [NR];
  logic          en   [NR];

  exp_t sb[$];
  int   vecs = 0;
  int   miss = 0;
  int   cyc  = 0;
  int   acc  = 0;
  int   wr_cnt = 0;
  int   wc [256];
  int   acc_base;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    vecs++;
    if (act !== req) begin
      miss++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  function automatic logic pending();
    for (int i = 0; i < NR; i++)
      if (en[i] && head[i] < tail[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Producers: present the head beat of each enabled, non-empty queue.
  always_comb begin
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    for (int i = 0; i < NR; i++) begin
      if (en[i] && head[i] < tail[i]) begin
        bus.req_valid[i]          = 1'b1;
        bus.req_last[i]           = pl[i][head[i]];
        bus.req_data[i*DW +: DW]  = pd[i][head[i]];
      end
    end
  end

  always @(posedge w_clk) begin
    cyc <= cyc + 1;
    if (wrst_n) begin
      for (int i = 0; i < NR; i++)
        if (bus.req_valid[i] && bus.req_ready[i]) head[i] <= head[i] + 1;
      acc <= acc + $countones(bus.req_valid & bus.req_ready);
    end
  end

  // Monitor: every FIFO write must match the next expected beat.
  always @(negedge w_clk) begin
    if (wrst_n && bus.w_en) begin
      wc[wr_cnt % 256] = cyc;
      wr_cnt++;
      chk("write_while_full", 32'(bus.full), 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_write", 32'(bus.data_in), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("write_grant_id", 32'(bus.grant_id), 32'(e.id));
        chk("write_data", 32'(bus.data_in), 32'(e.dat));
      end
    end
  end

  task automatic tick();
    @(posedge w_clk);
    #1;
  endtask

  task automatic load(input int r, input logic [DW-1:0] d, input logic l);
    pd[r][tail[r]] = d;
    pl[r][tail[r]] = l;
    tail[r]++;
  endtask

  task automatic expect_wr(input int r, input logic [DW-1:0] d);
    exp_t e;
    e.id  = 2'(r);
    e.dat = d;
    sb.push_back(e);
  endtask

  task automatic drain(input string nm, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 || bus.busy || pending()) begin
      @(negedge w_clk);
      n++;
      if (n > budget) begin
        chk({nm, "_drain_timeout"}, 32'd1, 32'd0);
        break;
      end
    end
    tick();
  endtask

  task automatic wait_acc(input string nm, input int target);
    int n;
    n = 0;
    while (acc - acc_base < target) begin
      tick();
      n++;
      if (n > 30) begin
        chk({nm, "_accept_timeout"}, 32'(acc - acc_base), 32'(target));
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w0;
    bus.full        = 1'b0;
    bus.write_error = 1'b0;
    for (int i = 0; i < NR; i++) begin
      head[i] = 0;
      tail[i] = 0;
      en[i]   = 1'b1;
    end

    // Reset state
    repeat (2) @(posedge w_clk);
    #1;
    chk("rst_w_en", 32'(bus.w_en), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_grant_id", 32'(bus.grant_id), 32'd0);
    chk("rst_err_sticky", 32'(bus.err_sticky), 32'd0);
    chk("rst_data_in", 32'(bus.data_in), 32'd0);
    wrst_n = 1'b1;
    tick();
    tick();

    // All four valid, no last: bursts of 4 in order 0,1,2,3,0
    w0 = wr_cnt;
    for (int k = 0; k < 8; k++) load(0, 8'h00 + 8'(k), 1'b0);
    for (int r = 1; r < NR; r++)
      for (int k = 0; k < 4; k++) load(r, 8'(r * 16 + k), 1'b0);
    for (int k = 0; k < 4; k++) expect_wr(0, 8'h00 + 8'(k));
    for (int r = 1; r < NR; r++)
      for (int k = 0; k < 4; k++) expect_wr(r, 8'(r * 16 + k));
    for (int k = 4; k < 8; k++) expect_wr(0, 8'h00 + 8'(k));
    drain("rr", 80);
    chk("rr_write_count", 32'(wr_cnt - w0), 32'd20);
    chk("rr_span_cycles", 32'(wc[(w0 + 19) % 256] - wc[w0 % 256]), 32'd23);
    chk("rr_idle_gap", 32'(wc[(w0 + 4) % 256] - wc[(w0 + 3) % 256]), 32'd2);

    // Requester 1 alone, 3 beats ending in last
    load(1, 8'hA1, 1'b0);
    load(1, 8'hA2, 1'b0);
    load(1, 8'hA3, 1'b1);
    expect_wr(1, 8'hA1);
    expect_wr(1, 8'hA2);
    expect_wr(1, 8'hA3);
    @(negedge w_clk);
    chk("r1_idle_no_write", 32'(bus.w_en), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge w_clk);
      chk("r1_w_en", 32'(bus.w_en), 32'd1);
    end
    @(negedge w_clk);
    chk("r1_busy_fall", 32'(bus.busy), 32'd0);
    chk("r1_grant_hold", 32'(bus.grant_id), 32'd1);
    tick();

    // rr_ptr now 2: requester 2 beats requester 0
    load(0, 8'h50, 1'b1);
    load(2, 8'h52, 1'b1);
    expect_wr(2, 8'h52);
    expect_wr(0, 8'h50);
    drain("ptr", 20);

    // Full for 3 cycles after beat 2 of requester 0
    acc_base = acc;
    for (int k = 0; k < 6; k++) begin
      load(0, 8'h60 + 8'(k), 1'b0);
      expect_wr(0, 8'h60 + 8'(k));
    end
    wait_acc("full", 2);
    bus.full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge w_clk);
      chk("full_w_en", 32'(bus.w_en), 32'd0);
      chk("full_req_ready0", 32'(bus.req_ready[0]), 32'd0);
      chk("full_busy_held", 32'(bus.busy), 32'd1);
    end
    @(posedge w_clk);
    #1;
    bus.full = 1'b0;
    chk("full_accepts_frozen", 32'(acc - acc_base), 32'd2);
    @(negedge w_clk);
    chk("resume_beat3", 32'(bus.w_en), 32'd1);
    @(negedge w_clk);
    chk("resume_beat4", 32'(bus.w_en), 32'd1);
    @(negedge w_clk);
    chk("max_burst_rotate", 32'(bus.busy), 32'd0);
    chk("max_burst_beats", 32'(acc - acc_base), 32'd4);
    drain("full", 30);
    chk("full_total_beats", 32'(acc - acc_base), 32'd6);

    // Single-cycle write_error pulse
    bus.write_error = 1'b1;
    @(negedge w_clk);
    chk("err_not_yet", 32'(bus.err_sticky), 32'd0);
    tick();
    bus.write_error = 1'b0;
    @(negedge w_clk);
    chk("err_set", 32'(bus.err_sticky), 32'd1);
    tick();
    load(1, 8'h71, 1'b0);
    load(1, 8'h72, 1'b1);
    expect_wr(1, 8'h71);
    expect_wr(1, 8'h72);
    drain("err", 20);
    chk("err_persists", 32'(bus.err_sticky), 32'd1);

    // Reset in the middle of a requester-2 burst
    acc_base = acc;
    for (int k = 0; k < 4; k++) load(2, 8'h80 + 8'(k), 1'b0);
    expect_wr(2, 8'h80);
    wait_acc("rst", 1);
    chk("pre_rst_w_en", 32'(bus.w_en), 32'd1);
    wrst_n = 1'b0;
    #1;
    chk("async_rst_w_en", 32'(bus.w_en), 32'd0);
    chk("async_rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("async_rst_busy", 32'(bus.busy), 32'd0);
    chk("async_rst_grant", 32'(bus.grant_id), 32'd0);
    chk("async_rst_err", 32'(bus.err_sticky), 32'd0);
    for (int i = 0; i < NR; i++) tail[i] = head[i];
    for (int r = 0; r < NR; r++) begin
      load(r, 8'h90 + 8'(r), 1'b1);
      expect_wr(r, 8'h90 + 8'(r));
    end
    tick();
    wrst_n = 1'b1;
    @(negedge w_clk);
    @(negedge w_clk);
    chk("post_rst_first_grant", 32'(bus.grant_id), 32'd0);
    chk("post_rst_busy", 32'(bus.busy), 32'd1);
    drain("post_rst", 30);

    // Requester 3 drops valid after one beat; next grant wraps to 0
    acc_base = acc;
    for (int k = 0; k < 3; k++) load(3, 8'hC0 + 8'(k), 1'b0);
    expect_wr(3, 8'hC0);
    wait_acc("abandon", 1);
    en[3] = 1'b0;
    load(0, 8'hD0, 1'b1);
    load(2, 8'hD2, 1'b1);
    expect_wr(0, 8'hD0);
    expect_wr(2, 8'hD2);
    @(negedge w_clk);
    chk("abandon_no_write", 32'(bus.w_en), 32'd0);
    @(negedge w_clk);
    chk("abandon_idle", 32'(bus.busy), 32'd0);
    @(negedge w_clk);
    chk("abandon_next_grant", 32'(bus.grant_id), 32'd0);
    drain("abandon", 30);
    chk("abandon_total_beats", 32'(acc - acc_base), 32'd3);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
